// File: rtl/ureg_dcd_pipe_if.sv
// Decoder-side bundle: instruction strobes and register addresses in; read/write-back addresses and stack status out.
// Latency: none (wires only). Backpressure: none at this level; ps_stall is carried as an output.
interface ureg_dcd_pipe_if #(
    parameter int UREG_AW    = 8,
    parameter int RF_AW      = 5,
    parameter int XB_AW      = 4,
    parameter int STCK_DEPTH = 8
);
    localparam int STCK_AW = $clog2(STCK_DEPTH + 1);

    logic               ps_pshstck;
    logic               ps_popstck;
    logic               ps_imminst;
    logic               ps_dminst;
    logic               ps_dmiaddinst;
    logic               ps_urgtrnsinst;
    logic               ps_dm_wrb;
    logic [UREG_AW-1:0] ps_ureg1_add;
    logic [UREG_AW-1:0] ps_ureg2_add;

    logic [XB_AW-1:0]   ps_xb_dm_rd_add;
    logic [XB_AW-1:0]   ps_xb_dm_wrt_add;
    logic [RF_AW-1:0]   ps_dg_rd_add;
    logic [RF_AW-1:0]   ps_rd_add;
    logic [RF_AW-1:0]   ps_dg_wrt_add;
    logic [RF_AW-1:0]   ps_wrt_add;
    logic               ps_xb_w_bcEn;
    logic               ps_dg_wrt_en;
    logic               ps_wrt_en;
    logic               ps_stall;
    logic [STCK_AW-1:0] ps_stck_lvl;
    logic               ps_stck_ovf;
    logic               ps_stck_unf;
    logic               ps_stck_err;

    modport master (
        output ps_pshstck, ps_popstck, ps_imminst, ps_dminst, ps_dmiaddinst,
               ps_urgtrnsinst, ps_dm_wrb, ps_ureg1_add, ps_ureg2_add,
        input  ps_xb_dm_rd_add, ps_xb_dm_wrt_add, ps_dg_rd_add, ps_rd_add,
               ps_dg_wrt_add, ps_wrt_add, ps_xb_w_bcEn, ps_dg_wrt_en, ps_wrt_en,
               ps_stall, ps_stck_lvl, ps_stck_ovf, ps_stck_unf, ps_stck_err
    );

    modport slave (
        input  ps_pshstck, ps_popstck, ps_imminst, ps_dminst, ps_dmiaddinst,
               ps_urgtrnsinst, ps_dm_wrb, ps_ureg1_add, ps_ureg2_add,
        output ps_xb_dm_rd_add, ps_xb_dm_wrt_add, ps_dg_rd_add, ps_rd_add,
               ps_dg_wrt_add, ps_wrt_add, ps_xb_w_bcEn, ps_dg_wrt_en, ps_wrt_en,
               ps_stall, ps_stck_lvl, ps_stck_ovf, ps_stck_unf, ps_stck_err
    );
endinterface

// File: rtl/ureg_dcd_pipe.sv
// Universal-register decoder: group-decoded read addresses, delayed write-back, RAW stall; stack checker under UREG_STCK_CHK_EN.
// Latency: read addresses and stall combinational; write-back controls exactly WB_LAT (1..3) cycles after decode.
// Backpressure: ps_stall asks the sequencer to hold the instruction; a bubble enters the write pipe meanwhile.
module ureg_dcd_pipe #(
    parameter int UREG_AW    = 8,
    parameter int RF_AW      = 5,
    parameter int XB_AW      = 4,
    parameter int WB_LAT     = 1,
    parameter int STCK_DEPTH = 8
) (
    input  logic           clk_dcd,
    input  logic           rst_n,
    ureg_dcd_pipe_if.slave dcd
);
    localparam int STCK_AW = $clog2(STCK_DEPTH + 1);
    localparam logic [RF_AW-1:0] STCK_REG = RF_AW'(4);

    typedef enum logic [1:0] {TGT_NONE, TGT_XB, TGT_DAG, TGT_RF} tgt_e;

    typedef struct packed {
        logic             xb_en;
        logic [XB_AW-1:0] xb_add;
        logic             dg_en;
        logic [RF_AW-1:0] dg_add;
        logic             rf_en;
        logic [RF_AW-1:0] rf_add;
    } wb_ent_t;

    function automatic tgt_e tgt_of(input logic [UREG_AW-1:0] a);
        case (a[UREG_AW-1 -: 4])
            4'h0:       return TGT_XB;
            4'h1, 4'h2: return TGT_DAG;
            4'h6, 4'h7: return TGT_RF;
            default:    return TGT_NONE;
        endcase
    endfunction

    tgt_e             t1, t2, rtgt;
    logic             dm_any, dm_wr, psh_pop, wr_q, rd_u1, rd_u2;
    logic [UREG_AW-1:0] rsrc;
    logic [XB_AW-1:0] xb_rd;
    logic [RF_AW-1:0] dg_rd, rf_rd;
    logic             stall;
    wb_ent_t          dec, ent0;
    wb_ent_t          pipe [1:WB_LAT];

    assign t1      = tgt_of(dcd.ps_ureg1_add);
    assign t2      = tgt_of(dcd.ps_ureg2_add);
    assign dm_any  = dcd.ps_dminst | dcd.ps_dmiaddinst;
    assign dm_wr   = dm_any & dcd.ps_dm_wrb;
    assign psh_pop = dcd.ps_pshstck & dcd.ps_popstck;
    // A simultaneous push+pop decodes as a push, so the pop term drops out of the write qualifier.
    assign wr_q    = (dcd.ps_popstck & ~psh_pop) | dcd.ps_imminst | dcd.ps_urgtrnsinst
                   | (dm_any & ~dcd.ps_dm_wrb);
    assign rd_u1   = dcd.ps_pshstck | dm_wr;
    assign rd_u2   = ~rd_u1 & dcd.ps_urgtrnsinst;
    assign rsrc    = rd_u1 ? dcd.ps_ureg1_add : dcd.ps_ureg2_add;
    assign rtgt    = rd_u1 ? t1 : t2;

    always_comb begin
        xb_rd = '0;
        dg_rd = '0;
        rf_rd = '0;
        if (rd_u1 || rd_u2) begin
            case (rtgt)
                TGT_XB:  xb_rd = rsrc[XB_AW-1:0];
                TGT_DAG: dg_rd = rsrc[RF_AW-1:0];
                TGT_RF:  rf_rd = rsrc[RF_AW-1:0];
                default: ;
            endcase
        end else if (dcd.ps_popstck) begin
            rf_rd = STCK_REG;
        end
    end

    always_comb begin
        dec = '0;
        if (wr_q) begin
            case (t1)
                TGT_XB:  begin dec.xb_en = 1'b1; dec.xb_add = dcd.ps_ureg1_add[XB_AW-1:0]; end
                TGT_DAG: begin dec.dg_en = 1'b1; dec.dg_add = dcd.ps_ureg1_add[RF_AW-1:0]; end
                TGT_RF:  begin dec.rf_en = 1'b1; dec.rf_add = dcd.ps_ureg1_add[RF_AW-1:0]; end
                default: ;
            endcase
        end else if (dcd.ps_pshstck) begin
            dec.rf_en  = 1'b1;
            dec.rf_add = STCK_REG;
        end
    end

    // Only entries still inside the pipe (not yet on the outputs) can be hazards; bubbles carry no enables.
    always_comb begin
        stall = 1'b0;
        for (int i = 1; i < WB_LAT; i++) begin
            if (pipe[i].xb_en && (xb_rd != '0) && (pipe[i].xb_add == xb_rd)) stall = 1'b1;
            if (pipe[i].dg_en && (dg_rd != '0) && (pipe[i].dg_add == dg_rd)) stall = 1'b1;
            if (pipe[i].rf_en && (rf_rd != '0) && (pipe[i].rf_add == rf_rd)) stall = 1'b1;
        end
    end

    assign ent0 = stall ? '0 : dec;

    always_ff @(posedge clk_dcd or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= WB_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[1] <= ent0;
            for (int i = 2; i <= WB_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dcd.ps_xb_dm_rd_add  = xb_rd;
    assign dcd.ps_xb_dm_wrt_add = dec.xb_add;
    assign dcd.ps_dg_rd_add     = dg_rd;
    assign dcd.ps_rd_add        = rf_rd;
    assign dcd.ps_stall         = stall;
    assign dcd.ps_xb_w_bcEn     = pipe[WB_LAT].xb_en;
    assign dcd.ps_dg_wrt_en     = pipe[WB_LAT].dg_en;
    assign dcd.ps_dg_wrt_add    = pipe[WB_LAT].dg_add;
    assign dcd.ps_wrt_en        = pipe[WB_LAT].rf_en;
    assign dcd.ps_wrt_add       = pipe[WB_LAT].rf_add;

`ifdef UREG_STCK_CHK_EN
    logic [STCK_AW-1:0] stck_lvl;
    logic               stck_ovf, stck_unf, stck_err;
    logic               do_psh, do_pop;

    assign do_psh = dcd.ps_pshstck & ~stall;
    assign do_pop = dcd.ps_popstck & ~stall;

    always_ff @(posedge clk_dcd or negedge rst_n) begin
        if (!rst_n) begin
            stck_lvl <= '0;
            stck_ovf <= 1'b0;
            stck_unf <= 1'b0;
            stck_err <= 1'b0;
        end else if (do_psh && do_pop) begin
            stck_err <= 1'b1;
        end else if (do_psh) begin
            if (stck_lvl == STCK_AW'(STCK_DEPTH)) stck_ovf <= 1'b1;
            else                                  stck_lvl <= stck_lvl + 1'b1;
        end else if (do_pop) begin
            if (stck_lvl == '0) stck_unf <= 1'b1;
            else                stck_lvl <= stck_lvl - 1'b1;
        end
    end

    assign dcd.ps_stck_lvl = stck_lvl;
    assign dcd.ps_stck_ovf = stck_ovf;
    assign dcd.ps_stck_unf = stck_unf;
    assign dcd.ps_stck_err = stck_err;
`else
    assign dcd.ps_stck_lvl = '0;
    assign dcd.ps_stck_ovf = 1'b0;
    assign dcd.ps_stck_unf = 1'b0;
    assign dcd.ps_stck_err = 1'b0;
`endif
endmodule

// File: tb/tb_ureg_dcd_pipe.sv
// Directed bench for ureg_dcd_pipe: three instances (WB_LAT 1/2/3) share one stimulus stream.
module tb_ureg_dcd_pipe;
    localparam logic [6:0] PSH = 7'b1000000, POP = 7'b0100000, IMM = 7'b0010000,
                           DM  = 7'b0001000, DMA = 7'b0000100, URG = 7'b0000010,
                           WRB = 7'b0000001;
`ifdef UREG_STCK_CHK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] stb;
    logic [7:0] u1, u2;
    int         n_total = 0, n_pass = 0;

    always #5 clk = ~clk;

    ureg_dcd_pipe_if i1 ();
    ureg_dcd_pipe_if i2 ();
    ureg_dcd_pipe_if i3 ();

    assign {i1.ps_pshstck, i1.ps_popstck, i1.ps_imminst, i1.ps_dminst, i1.ps_dmiaddinst,
            i1.ps_urgtrnsinst, i1.ps_dm_wrb} = stb;
    assign {i2.ps_pshstck, i2.ps_popstck, i2.ps_imminst, i2.ps_dminst, i2.ps_dmiaddinst,
            i2.ps_urgtrnsinst, i2.ps_dm_wrb} = stb;
    assign {i3.ps_pshstck, i3.ps_popstck, i3.ps_imminst, i3.ps_dminst, i3.ps_dmiaddinst,
            i3.ps_urgtrnsinst, i3.ps_dm_wrb} = stb;
    assign i1.ps_ureg1_add = u1;  assign i1.ps_ureg2_add = u2;
    assign i2.ps_ureg1_add = u1;  assign i2.ps_ureg2_add = u2;
    assign i3.ps_ureg1_add = u1;  assign i3.ps_ureg2_add = u2;

    ureg_dcd_pipe #(.WB_LAT(1)) u_d1 (.clk_dcd(clk), .rst_n(rst_n), .dcd(i1));
    ureg_dcd_pipe #(.WB_LAT(2)) u_d2 (.clk_dcd(clk), .rst_n(rst_n), .dcd(i2));
    ureg_dcd_pipe #(.WB_LAT(3)) u_d3 (.clk_dcd(clk), .rst_n(rst_n), .dcd(i3));

    typedef struct {
        logic [6:0] stb;
        logic [7:0] u1, u2;
        logic [3:0] xb_rd, xb_wr;
        logic [4:0] dg_rd, rd;
        logic       stall;
        logic       xb_bc, dg_en;
        logic [4:0] dg_add;
        logic       wr_en;
        logic [4:0] wr_add;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          stb        u1     u2     xbrd  xbwr  dgrd   rd     stl   bc    dgen  dgadd  wren  wradd
        vecs[0] = '{URG,       8'h63, 8'h15, 4'h0, 4'h0, 5'h15, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b1, 5'h03};
        vecs[1] = '{DM | WRB,  8'h07, 8'h00, 4'h7, 4'h0, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 5'h00};
        vecs[2] = '{DM,        8'h0A, 8'h00, 4'h0, 4'hA, 5'h00, 5'h00, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 5'h00};
        vecs[3] = '{IMM,       8'h1F, 8'h00, 4'h0, 4'h0, 5'h00, 5'h00, 1'b0, 1'b0, 1'b1, 5'h1F, 1'b0, 5'h00};
        vecs[4] = '{PSH,       8'h75, 8'h00, 4'h0, 4'h0, 5'h00, 5'h15, 1'b0, 1'b0, 1'b0, 5'h00, 1'b1, 5'h04};
        vecs[5] = '{POP,       8'h22, 8'h00, 4'h0, 4'h0, 5'h00, 5'h04, 1'b0, 1'b0, 1'b1, 5'h02, 1'b0, 5'h00};
        vecs[6] = '{DMA | WRB, 8'h2C, 8'h61, 4'h0, 4'h0, 5'h0C, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 5'h00};
        vecs[7] = '{URG,       8'h45, 8'h6E, 4'h0, 4'h0, 5'h00, 5'h0E, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 5'h00};
        vecs[8] = '{URG,       8'h0F, 8'h38, 4'h0, 4'hF, 5'h00, 5'h00, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 5'h00};
        vecs[9] = '{7'b0,      8'h63, 8'h15, 4'h0, 4'h0, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 5'h00};

        rst_n = 1'b0;
        stb   = '0;
        u1    = '0;
        u2    = '0;
        repeat (2) tick();

        chk("rst_d1_wrt_en",  i1.ps_wrt_en,    0);
        chk("rst_d1_dg_en",   i1.ps_dg_wrt_en, 0);
        chk("rst_d1_xb_bc",   i1.ps_xb_w_bcEn, 0);
        chk("rst_d2_wrt_add", i2.ps_wrt_add,   0);
        chk("rst_d3_wrt_en",  i3.ps_wrt_en,    0);
        chk("rst_stck_lvl",   i1.ps_stck_lvl,  0);
        chk("rst_stck_ovf",   i1.ps_stck_ovf,  0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table vectors on the WB_LAT=1 instance: read side same cycle, write-back one cycle later.
        for (int v = 0; v < 10; v++) begin
            stb = vecs[v].stb;
            u1  = vecs[v].u1;
            u2  = vecs[v].u2;
            @(negedge clk);
            chk($sformatf("v%0d_xb_rd", v),  i1.ps_xb_dm_rd_add,  vecs[v].xb_rd);
            chk($sformatf("v%0d_xb_wr", v),  i1.ps_xb_dm_wrt_add, vecs[v].xb_wr);
            chk($sformatf("v%0d_dg_rd", v),  i1.ps_dg_rd_add,     vecs[v].dg_rd);
            chk($sformatf("v%0d_rd", v),     i1.ps_rd_add,        vecs[v].rd);
            chk($sformatf("v%0d_stall", v),  i1.ps_stall,         vecs[v].stall);
            tick();
            chk($sformatf("v%0d_xb_bc", v),  i1.ps_xb_w_bcEn,     vecs[v].xb_bc);
            chk($sformatf("v%0d_dg_en", v),  i1.ps_dg_wrt_en,     vecs[v].dg_en);
            chk($sformatf("v%0d_dg_add", v), i1.ps_dg_wrt_add,    vecs[v].dg_add);
            chk($sformatf("v%0d_wr_en", v),  i1.ps_wrt_en,        vecs[v].wr_en);
            chk($sformatf("v%0d_wr_add", v), i1.ps_wrt_add,       vecs[v].wr_add);
        end
        stb = '0;
        repeat (4) tick();

        // RAW hazard on WB_LAT=2: write RF 4, then read it next cycle.
        stb = IMM; u1 = 8'h64; u2 = 8'h00;
        @(negedge clk);
        chk("haz_a_stall", i2.ps_stall, 0);
        tick();
        stb = URG; u1 = 8'h40; u2 = 8'h64;
        @(negedge clk);
        chk("haz_b_stall",   i2.ps_stall,  1);
        chk("haz_b_rd_add",  i2.ps_rd_add, 4);
        chk("haz_b_wrt_en",  i2.ps_wrt_en, 0);
        chk("haz_b_d1_nostall", i1.ps_stall, 0);
        tick();
        chk("haz_c_wrt_en",  i2.ps_wrt_en,  1);
        chk("haz_c_wrt_add", i2.ps_wrt_add, 4);
        @(negedge clk);
        chk("haz_c_stall",   i2.ps_stall, 0);
        tick();
        chk("haz_bubble_wrt_en", i2.ps_wrt_en, 0);
        stb = '0; u1 = '0; u2 = '0;
        repeat (4) tick();

        // Reset with two write-backs in flight on WB_LAT=3.
        stb = IMM; u1 = 8'h61;
        tick();
        u1 = 8'h62;
        tick();
        stb = '0; u1 = '0;
        tick();
        chk("pre_rst_d3_wrt_en",  i3.ps_wrt_en,  1);
        chk("pre_rst_d3_wrt_add", i3.ps_wrt_add, 1);
        chk("pre_rst_d2_wrt_add", i2.ps_wrt_add, 2);
        rst_n = 1'b0;
        #1;
        chk("rst_now_d3_wrt_en",  i3.ps_wrt_en,  0);
        chk("rst_now_d3_wrt_add", i3.ps_wrt_add, 0);
        chk("rst_now_d2_wrt_en",  i2.ps_wrt_en,  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst%0d_d3_wrt_en", k), i3.ps_wrt_en,    0);
            chk($sformatf("post_rst%0d_d2_wrt_en", k), i2.ps_wrt_en,    0);
            chk($sformatf("post_rst%0d_d3_dg_en", k),  i3.ps_dg_wrt_en, 0);
        end

        // Stack depth tracking and sticky flags.
        stb = PSH; u1 = 8'h00;
        repeat (4) tick();
        chk("stk_lvl4", i1.ps_stck_lvl, STK ? 4 : 0);
        repeat (4) tick();
        chk("stk_lvl8",     i1.ps_stck_lvl, STK ? 8 : 0);
        chk("stk_ovf_at8",  i1.ps_stck_ovf, 0);
        tick();
        chk("stk_lvl_sat",  i1.ps_stck_lvl, STK ? 8 : 0);
        chk("stk_ovf",      i1.ps_stck_ovf, STK ? 1 : 0);
        stb = PSH | POP;
        tick();
        chk("stk_err",      i1.ps_stck_err, STK ? 1 : 0);
        chk("stk_err_lvl",  i1.ps_stck_lvl, STK ? 8 : 0);
        stb = POP;
        tick();
        chk("stk_pop_lvl",  i1.ps_stck_lvl, STK ? 7 : 0);
        chk("stk_unf",      i1.ps_stck_unf, 0);
        stb = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ureg_dcd_pipe.md
UREG_DCD_PIPE -- requirements
Module: ureg_dcd_pipe

Interface
REQ-001 Parameter UREG_AW, default 8, universal-register address width; bits [UREG_AW-1:UREG_AW-4] are the group field.
REQ-002 Parameter RF_AW, default 5, register-file and DAG address width; XB_AW, default 4, crossbar/DM address width.
REQ-003 Parameter WB_LAT, default 1, write-back delay in cycles; legal range 1..3.
REQ-004 Parameter STCK_DEPTH, default 8, PC-stack depth; STCK_AW = clog2(STCK_DEPTH+1).
REQ-005 clk_dcd  in  1  decoder clock; all state on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 ps_pshstck, ps_popstck, ps_imminst, ps_dminst, ps_dmiaddinst, ps_urgtrnsinst, ps_dm_wrb  in  1 each  instruction-class strobes; ps_dm_wrb=1 is a DM write.
REQ-008 ps_ureg1_add, ps_ureg2_add  in  UREG_AW  destination/source universal-register addresses.
REQ-009 ps_xb_dm_rd_add, ps_xb_dm_wrt_add  out  XB_AW  combinational crossbar read/write addresses.
REQ-010 ps_dg_rd_add, ps_rd_add  out  RF_AW  combinational DAG and register-file read addresses.
REQ-011 ps_dg_wrt_add, ps_wrt_add  out  RF_AW; ps_xb_w_bcEn, ps_dg_wrt_en, ps_wrt_en  out  1  delayed write-back controls.
REQ-012 ps_stall  out  1  combinational read-after-write hazard stall.
REQ-013 ps_stck_lvl  out  STCK_AW; ps_stck_ovf, ps_stck_unf, ps_stck_err  out  1 each  stack status.

Function
REQ-014 Group decode: 0x0 -> XB (addr bits [XB_AW-1:0]); 0x1, 0x2 -> DAG; 0x6, 0x7 -> RF (addr bits [RF_AW-1:0]); any other group -> no target, address 0.
REQ-015 Read source priority: pshstck or DM write (dminst|dmiaddinst with dm_wrb=1) -> ureg1; else urgtrnsinst -> ureg2; else popstck -> ps_rd_add = 5'b00100 (stack register), others 0; else all read addresses 0.
REQ-016 Write qualifier W = popstck | imminst | urgtrnsinst | ((dminst|dmiaddinst) & !dm_wrb); W selects ureg1 as destination; ps_xb_dm_wrt_add is combinational from ureg1 when W, else 0.
REQ-017 Stage-0 write entry: W -> group-decoded enables/addresses from ureg1; else pshstck -> ps_wrt_en=1, ps_wrt_add=5'b00100; else all enables 0, addresses 0.
REQ-018 Write entry passes through a WB_LAT-deep register pipeline; outputs of REQ-011 equal the stage-0 entry exactly WB_LAT cycles later.
REQ-019 ps_stall=1 when any valid pipeline entry not yet presented on the outputs targets the same group class (XB/DAG/RF) and address as the current nonzero read address.
REQ-020 While ps_stall=1: a bubble (all enables 0) enters stage 0 instead of the decoded write; pipeline keeps advancing; read outputs remain driven.
REQ-021 Stall clears no later than WB_LAT cycles after assertion; with WB_LAT=1 and no outstanding entries, ps_stall is never asserted.
REQ-022 Pipeline bubbles and entries with all enables 0 never cause a stall.

Reset
REQ-023 rst_n=0 asynchronously clears all pipeline stages, ps_stck_lvl, ps_stck_ovf, ps_stck_unf, ps_stck_err; all registered outputs read 0.
REQ-024 Reset mid-instruction discards all pending write-backs; no write enable asserts in the first WB_LAT cycles after release unless a new instruction is presented.

Configuration
REQ-025 Macro UREG_STCK_CHK_EN: when defined, a stack depth counter is compiled in: push (not stalled) increments, pop decrements, saturating at STCK_DEPTH and 0.
REQ-026 With UREG_STCK_CHK_EN: push at STCK_DEPTH sets sticky ps_stck_ovf; pop at 0 sets sticky ps_stck_unf; push and pop together set sticky ps_stck_err, leave the level unchanged, and decode as push; flags clear only on reset.
REQ-027 Without UREG_STCK_CHK_EN: ps_stck_lvl, ps_stck_ovf, ps_stck_unf, ps_stck_err tied to 0; no counter logic.

Verification
REQ-028 urgtrnsinst, ureg1=0x63, ureg2=0x15, WB_LAT=1 -> ps_dg_rd_add=5'h15 same cycle; ps_wrt_en=1, ps_wrt_add=5'h03 one cycle later.
REQ-029 dminst, dm_wrb=1, ureg1=0x07 -> ps_xb_dm_rd_add=4'h7, ps_xb_dm_wrt_add=0, no write enable.
REQ-030 WB_LAT=2: imminst ureg1=0x64, next cycle urgtrnsinst ureg2=0x64 -> ps_stall=1 for one cycle, bubble inserted, stall clears when ps_wrt_add=5'h04 issues.
REQ-031 UREG_STCK_CHK_EN, STCK_DEPTH=8: 9 pushes -> ps_stck_lvl=8, ps_stck_ovf=1; push+pop same cycle -> ps_stck_err=1, level unchanged.
REQ-032 rst_n low for 1 cycle with two writes in flight (WB_LAT=3) -> all outputs 0 immediately; no write enable for 3 cycles after release.
